// File: rtl/logo_anim_ctrl_pkg.sv
// Shared VGA-side definitions for the logo animation controller: coordinate width,
// animation state encoding and saturating coordinate helpers.
package logo_anim_ctrl_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_ext_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RIGHT  = 3'd1,
        ST_HOLD_R = 3'd2,
        ST_LEFT   = 3'd3,
        ST_HOLD_L = 3'd4
    } anim_state_t;

    // One extra bit of headroom so sums and differences never wrap before clamping.
    function automatic coord_t clamp_coord(input coord_ext_t v, input coord_t lo, input coord_t hi);
        if (v < {1'b0, lo}) begin
            return lo;
        end else if (v > {1'b0, hi}) begin
            return hi;
        end
        return v[COORD_W-1:0];
    endfunction

    function automatic coord_t sat_down(input coord_t v, input coord_ext_t step, input coord_t lo, input coord_t hi);
        if ({1'b0, v} < step) begin
            return lo;
        end
        return clamp_coord({1'b0, v} - step, lo, hi);
    endfunction

endpackage

// File: rtl/logo_anim_ctrl_if.sv
// Control/status bundle between the VGA timing side and the logo animation controller.
interface logo_anim_ctrl_if;
    import logo_anim_ctrl_pkg::*;

    logic   enable;
    logic   frame_start;
    logic   load;
    coord_t load_value;
    coord_t delt;
    logic   dir;
    logic   moving;
    logic   step_pulse;

    modport master (
        output enable, frame_start, load, load_value,
        input  delt, dir, moving, step_pulse
    );

    modport slave (
        input  enable, frame_start, load, load_value,
        output delt, dir, moving, step_pulse
    );
endinterface

// File: rtl/logo_anim_ctrl_frame_tick_div.sv
// Counts frame_start pulses and flags the pulse that reaches a programmable terminal count.
module frame_tick_div #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] terminal,
    output logic         tick
);
    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign tick = advance && (count_reg == terminal);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (advance) begin
            count_next = tick ? '0 : count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/logo_anim_ctrl.sv
// Bounces the logo horizontal offset between two end stops, advancing once every
// FRAME_DIV frames and pausing PAUSE_FRAMES frames at each end.
module logo_anim_ctrl
    import logo_anim_ctrl_pkg::*;
#(
    parameter int DELT_MIN     = 0,
    parameter int DELT_MAX     = 100,
    parameter int STEP         = 1,
    parameter int FRAME_DIV    = 2,
    parameter int PAUSE_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    logo_anim_ctrl_if.slave bus
);
    localparam coord_t     D_LO   = coord_t'(DELT_MIN);
    localparam coord_t     D_HI   = coord_t'(DELT_MAX);
    localparam coord_ext_t STEP_X = coord_ext_t'(STEP);
    localparam int CNT_TOP = (FRAME_DIV > PAUSE_FRAMES) ? FRAME_DIV : PAUSE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    // Assertion is immediate; release is retimed so no flop sees a runt recovery.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    anim_state_t state_reg, state_next;
    coord_t      delt_reg, delt_next;
    logic        dir_reg, dir_next;
    logic        moving_reg, moving_next;
    logic        step_pulse_reg, step_pulse_next;

    logic             cnt_clear;
    logic             cnt_advance;
    logic             cnt_tick;
    logic [CNT_W-1:0] cnt_terminal;

    frame_tick_div #(.W(CNT_W)) u_frame_tick_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .advance  (cnt_advance),
        .terminal (cnt_terminal),
        .tick     (cnt_tick)
    );

    always_comb begin
        state_next   = state_reg;
        delt_next    = delt_reg;
        dir_next     = dir_reg;
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
        cnt_terminal = ((state_reg == ST_HOLD_R) || (state_reg == ST_HOLD_L))
                       ? CNT_W'(PAUSE_FRAMES - 1) : CNT_W'(FRAME_DIV - 1);

        if (bus.load) begin
            // A load pre-empts this frame's advance and leaves the state alone.
            delt_next = clamp_coord({1'b0, bus.load_value}, D_LO, D_HI);
            cnt_clear = 1'b1;
        end else if (bus.frame_start) begin
            if (!bus.enable) begin
                state_next = ST_IDLE;
                cnt_clear  = 1'b1;
            end else begin
                unique case (state_reg)
                    ST_IDLE: begin
                        state_next = ST_RIGHT;
                        dir_next   = 1'b0;
                        cnt_clear  = 1'b1;
                    end
                    ST_RIGHT: begin
                        if (delt_reg == D_HI) begin
                            state_next = ST_HOLD_R;
                            cnt_clear  = 1'b1;
                        end else begin
                            cnt_advance = 1'b1;
                            if (cnt_tick) begin
                                delt_next = clamp_coord({1'b0, delt_reg} + STEP_X, D_LO, D_HI);
                                if (delt_next == D_HI) begin
                                    state_next = ST_HOLD_R;
                                    cnt_clear  = 1'b1;
                                end
                            end
                        end
                    end
                    ST_HOLD_R: begin
                        cnt_advance = 1'b1;
                        if (cnt_tick) begin
                            state_next = ST_LEFT;
                            dir_next   = 1'b1;
                            cnt_clear  = 1'b1;
                        end
                    end
                    ST_LEFT: begin
                        if (delt_reg == D_LO) begin
                            state_next = ST_HOLD_L;
                            cnt_clear  = 1'b1;
                        end else begin
                            cnt_advance = 1'b1;
                            if (cnt_tick) begin
                                delt_next = sat_down(delt_reg, STEP_X, D_LO, D_HI);
                                if (delt_next == D_LO) begin
                                    state_next = ST_HOLD_L;
                                    cnt_clear  = 1'b1;
                                end
                            end
                        end
                    end
                    ST_HOLD_L: begin
                        cnt_advance = 1'b1;
                        if (cnt_tick) begin
                            state_next = ST_RIGHT;
                            dir_next   = 1'b0;
                            cnt_clear  = 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        cnt_clear  = 1'b1;
                    end
                endcase
            end
        end

        moving_next     = (state_next == ST_RIGHT) || (state_next == ST_LEFT);
        step_pulse_next = (delt_next != delt_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            delt_reg       <= D_LO;
            dir_reg        <= 1'b0;
            moving_reg     <= 1'b0;
            step_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            delt_reg       <= delt_next;
            dir_reg        <= dir_next;
            moving_reg     <= moving_next;
            step_pulse_reg <= step_pulse_next;
        end
    end

    assign bus.delt       = delt_reg;
    assign bus.dir        = dir_reg;
    assign bus.moving     = moving_reg;
    assign bus.step_pulse = step_pulse_reg;
endmodule

// File: tb/tb_logo_anim_ctrl.sv
// Directed and randomized checks of logo_anim_ctrl against a frame-level behavioural model.
module tb_logo_anim_ctrl;
    localparam int P_MIN   = 0;
    localparam int P_MAX   = 8;
    localparam int P_STEP  = 3;
    localparam int P_DIV   = 1;
    localparam int P_PAUSE = 2;

    localparam int MD_IDLE  = 0;
    localparam int MD_RIGHT = 1;
    localparam int MD_HOLDR = 2;
    localparam int MD_LEFT  = 3;
    localparam int MD_HOLDL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logo_anim_ctrl_if bus();

    logo_anim_ctrl #(
        .DELT_MIN     (P_MIN),
        .DELT_MAX     (P_MAX),
        .STEP         (P_STEP),
        .FRAME_DIV    (P_DIV),
        .PAUSE_FRAMES (P_PAUSE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: position in pixels, phase of the bounce, frames spent in the current phase.
    int m_mode, m_pos, m_frames, m_dir, m_step, m_steps_total, obs_steps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = MD_IDLE; m_pos = P_MIN; m_frames = 0; m_dir = 0; m_step = 0;
    endtask

    task automatic model_step(input logic en, input logic fs, input logic ld, input int lv);
        int prev;
        prev = m_pos;
        if (ld) begin
            m_pos = (lv < P_MIN) ? P_MIN : ((lv > P_MAX) ? P_MAX : lv);
            m_frames = 0;
        end else if (fs) begin
            if (!en) begin
                m_mode = MD_IDLE;
                m_frames = 0;
            end else if (m_mode == MD_IDLE) begin
                m_mode = MD_RIGHT; m_dir = 0; m_frames = 0;
            end else if (m_mode == MD_RIGHT || m_mode == MD_LEFT) begin
                int stop;
                stop = (m_mode == MD_RIGHT) ? P_MAX : P_MIN;
                if (m_pos != stop) begin
                    m_frames++;
                    if (m_frames == P_DIV) begin
                        m_frames = 0;
                        if (m_mode == MD_RIGHT) m_pos = (m_pos + P_STEP > P_MAX) ? P_MAX : m_pos + P_STEP;
                        else                    m_pos = (m_pos - P_STEP < P_MIN) ? P_MIN : m_pos - P_STEP;
                    end
                end
                if (m_pos == stop) begin
                    m_mode = (m_mode == MD_RIGHT) ? MD_HOLDR : MD_HOLDL;
                    m_frames = 0;
                end
            end else begin
                m_frames++;
                if (m_frames == P_PAUSE) begin
                    m_frames = 0;
                    m_mode = (m_mode == MD_HOLDR) ? MD_LEFT : MD_RIGHT;
                    m_dir = (m_mode == MD_LEFT) ? 1 : 0;
                end
            end
        end
        m_step = (m_pos != prev) ? 1 : 0;
        m_steps_total += m_step;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".delt"},       32'(bus.delt),       32'(m_pos));
        chk({ctx, ".dir"},        32'(bus.dir),        32'(m_dir));
        chk({ctx, ".moving"},     32'(bus.moving),     32'((m_mode == MD_RIGHT || m_mode == MD_LEFT) ? 1 : 0));
        chk({ctx, ".step_pulse"}, 32'(bus.step_pulse), 32'(m_step));
    endtask

    task automatic cycle(input string ctx, input logic en, input logic fs, input logic ld, input int lv);
        bus.enable      = en;
        bus.frame_start = fs;
        bus.load        = ld;
        bus.load_value  = 11'(lv);
        @(posedge clk);
        model_step(en, fs, ld, lv);
        #1;
        if (bus.step_pulse === 1'b1) obs_steps++;
        check_all(ctx);
        bus.frame_start = 1'b0;
        bus.load        = 1'b0;
    endtask

    task automatic frame(input string ctx, input logic en);
        cycle(ctx, en, 1'b1, 1'b0, 0);
        cycle(ctx, en, 1'b0, 1'b0, 0);
        cycle(ctx, en, 1'b0, 1'b0, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle("post_rst", bus.enable, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.enable = 1'b0; bus.frame_start = 1'b0; bus.load = 1'b0; bus.load_value = '0;
        m_steps_total = 0; obs_steps = 0;
        model_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        release_reset();

        // Run right to the stop: 0,3,6,8 then hold.
        obs_steps = 0; m_steps_total = 0;
        for (int i = 0; i < 4; i++) frame("run_right", 1'b1);
        chk("right_end.delt", 32'(bus.delt), 32'(P_MAX));
        chk("right_end.moving", 32'(bus.moving), 0);
        chk("right_steps", 32'(obs_steps), 32'(m_steps_total));

        // Pause then return left: 5,2,0 then hold.
        for (int i = 0; i < 2; i++) frame("hold_r", 1'b1);
        chk("left.dir", 32'(bus.dir), 1);
        chk("left.moving", 32'(bus.moving), 1);
        for (int i = 0; i < 3; i++) frame("run_left", 1'b1);
        chk("left_end.delt", 32'(bus.delt), 32'(P_MIN));
        chk("left_end.moving", 32'(bus.moving), 0);

        // Out-of-range load while RIGHT at 3 clamps to the stop, then holds without moving.
        for (int i = 0; i < 3; i++) frame("to_right3", 1'b1);
        chk("at3.delt", 32'(bus.delt), 3);
        cycle("load50", 1'b1, 1'b0, 1'b1, 50);
        chk("load50.delt", 32'(bus.delt), 8);
        frame("after_load50", 1'b1);
        chk("after_load50.delt", 32'(bus.delt), 8);
        chk("after_load50.moving", 32'(bus.moving), 0);

        // Load colliding with frame_start at 0 in RIGHT.
        for (int i = 0; i < 7; i++) frame("to_right0", 1'b1);
        chk("at0.moving", 32'(bus.moving), 1);
        chk("at0.dir", 32'(bus.dir), 0);
        cycle("load4_fs", 1'b1, 1'b1, 1'b1, 4);
        chk("load4.delt", 32'(bus.delt), 4);
        frame("after_load4", 1'b1);
        chk("after_load4.delt", 32'(bus.delt), 7);

        // Drop enable mid-RIGHT at 6, then asynchronous reset between edges.
        cycle("load3", 1'b1, 1'b0, 1'b1, 3);
        frame("to6", 1'b1);
        chk("at6.delt", 32'(bus.delt), 6);
        cycle("en_low_nofs", 1'b0, 1'b0, 1'b0, 0);
        chk("en_low_nofs.moving", 32'(bus.moving), 1);
        frame("disable", 1'b0);
        chk("disable.delt", 32'(bus.delt), 6);
        chk("disable.moving", 32'(bus.moving), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        release_reset();
        cycle("no_fs_after_rst", 1'b1, 1'b0, 1'b0, 0);
        chk("no_fs_after_rst.moving", 32'(bus.moving), 0);
        frame("first_fs", 1'b1);

        // Randomized traffic, including loads far outside the range.
        for (int i = 0; i < 600; i++) begin
            logic en, fs, ld;
            int lv;
            en = ($urandom_range(7) != 0);
            fs = ($urandom_range(2) == 0);
            ld = ($urandom_range(11) == 0);
            lv = ($urandom_range(1) == 0) ? int'($urandom_range(12)) : int'($urandom_range(2047));
            cycle("random", en, fs, ld, lv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
